// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - command sequencer driving a 16x16 single-port registered-read RAM
// All RAM pins and rsp_* come straight from flops; busy/cmd_ready decode the state flop.
module ram_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic          ram_we_n,
  output logic          ram_re_n,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_RDWAIT, S_FILL, S_RESP
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ram_we_n_q, ram_we_n_d;
  logic          ram_re_n_q, ram_re_n_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic          accept;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      ram_we_n_q  <= 1'b1;
      ram_re_n_q  <= 1'b1;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      ram_we_n_q  <= ram_we_n_d;
      ram_re_n_q  <= ram_re_n_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Reserved ops spend one strobe-less cycle in WRITE so they answer one cycle after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b01:   state_d = S_READ;
            2'b10:   state_d = S_FILL;
            default: state_d = S_WRITE;
          endcase
        end
      end
      S_WRITE:  state_d = S_RESP;
      S_READ:   state_d = S_RDWAIT;
      S_RDWAIT: state_d = S_RESP;
      S_FILL:   if (cnt_q == LAST) state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops on the same edge.
  always_comb begin
    data_d      = data_q;
    err_d       = err_q;
    if (accept) begin
      data_d = cmd_data;
      err_d  = (cmd_op == 2'b11);
    end
    cnt_d       = '0;
    ram_we_n_d  = 1'b1;
    ram_re_n_d  = 1'b1;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_d)
      S_WRITE: begin
        ram_we_n_d = err_d;
        if (!err_d) begin
          ram_addr_d  = cmd_addr;
          ram_wdata_d = cmd_data;
        end
      end
      S_READ: begin
        ram_re_n_d = 1'b0;
        ram_addr_d = cmd_addr;
      end
      S_FILL: begin
        ram_we_n_d  = 1'b0;
        cnt_d       = (state_q == S_FILL) ? cnt_q + 1'b1 : '0;
        ram_addr_d  = cnt_d;
        ram_wdata_d = data_d;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        if (state_q != S_RESP) begin
          rsp_err_d  = err_q;
          rsp_data_d = (state_q == S_RDWAIT) ? ram_rdata :
                       (err_q ? '0 : data_q);
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ram_we_n  = ram_we_n_q;
  assign ram_re_n  = ram_re_n_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - directed self-checking bench for ram_ctrl with a behavioural RAM
module tb_ram_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          ram_we_n, ram_re_n;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  int            lat, we_cnt, re_cnt;
  logic [DW-1:0] r_data;
  logic          r_err, addr_ok, both_low;

  ram_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .ram_we_n(ram_we_n), .ram_re_n(ram_re_n),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read, cleared by the shared reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ram_rdata <= '0;
    end else begin
      if (!ram_we_n) mem[ram_addr] <= ram_wdata;
      if (!ram_re_n) ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int guard;
    rsp_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 100) begin @(negedge clk); guard++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(posedge clk); #1 cmd_valid = 1'b0;
    lat = 0; we_cnt = 0; re_cnt = 0; addr_ok = 1'b1; both_low = 1'b0;
    @(negedge clk);
    while (!rsp_valid && lat <= 40) begin
      if (!ram_we_n) begin
        if (op == 2'b10 && ram_addr !== we_cnt[AW-1:0]) addr_ok = 1'b0;
        we_cnt++;
      end
      if (!ram_re_n) re_cnt++;
      if (!ram_we_n && !ram_re_n) both_low = 1'b1;
      lat++;
      @(negedge clk);
    end
    if (!ram_we_n) we_cnt++;
    if (!ram_re_n) re_cnt++;
    r_data = rsp_data; r_err = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'h2; cmd_data = 16'h7777;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({busy, ram_we_n, ram_re_n, rsp_valid, rsp_err, cmd_ready} !== 6'b011001) begin
      n_bad++; $display("FAIL reset_flags: got %b want 011001", {busy, ram_we_n, ram_re_n, rsp_valid, rsp_err, cmd_ready});
    end
    n_cmp++; if (ram_addr !== 4'h0 || ram_wdata !== 16'h0) begin
      n_bad++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h want 0/0000", ram_addr, ram_wdata);
    end
    n_cmp++; if (rsp_data !== 16'h0) begin
      n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data);
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after: busy got %b want 0", busy); end
  endtask

  task automatic test_read_after_reset();
    run_cmd(2'b01, 4'h5, 16'h0);
    n_cmp++; if (r_data !== 16'h0 || r_err !== 1'b0) begin
      n_bad++; $display("FAIL read_fresh_data: got %h err=%b want 0000 err=0", r_data, r_err);
    end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL read_latency: got %0d want 2", lat); end
    n_cmp++; if (re_cnt !== 1 || we_cnt !== 0) begin
      n_bad++; $display("FAIL read_strobes: got re=%0d we=%0d want re=1 we=0", re_cnt, we_cnt);
    end
  endtask

  task automatic test_write_read();
    run_cmd(2'b00, 4'h3, 16'hBEEF);
    n_cmp++; if (r_data !== 16'hBEEF || r_err !== 1'b0) begin
      n_bad++; $display("FAIL write_rsp: got %h err=%b want beef err=0", r_data, r_err);
    end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL write_latency: got %0d want 1", lat); end
    n_cmp++; if (we_cnt !== 1 || re_cnt !== 0) begin
      n_bad++; $display("FAIL write_strobes: got we=%0d re=%0d want we=1 re=0", we_cnt, re_cnt);
    end
    run_cmd(2'b01, 4'h3, 16'h0);
    n_cmp++; if (r_data !== 16'hBEEF) begin n_bad++; $display("FAIL readback_3: got %h want beef", r_data); end
    n_cmp++; if (re_cnt !== 1 || we_cnt !== 0 || both_low !== 1'b0) begin
      n_bad++; $display("FAIL readback_strobes: got re=%0d we=%0d both=%b want 1/0/0", re_cnt, we_cnt, both_low);
    end
  endtask

  task automatic test_fill();
    logic [AW-1:0] al [3];
    al[0] = 4'h0; al[1] = 4'h7; al[2] = 4'hF;
    run_cmd(2'b10, 4'h9, 16'hA5A5);
    n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL fill_latency: got %0d want 16", lat); end
    n_cmp++; if (we_cnt !== 16 || re_cnt !== 0) begin
      n_bad++; $display("FAIL fill_strobes: got we=%0d re=%0d want 16/0", we_cnt, re_cnt);
    end
    n_cmp++; if (addr_ok !== 1'b1) begin n_bad++; $display("FAIL fill_addr_seq: got %b want 1", addr_ok); end
    n_cmp++; if (r_data !== 16'hA5A5 || r_err !== 1'b0) begin
      n_bad++; $display("FAIL fill_rsp: got %h err=%b want a5a5 err=0", r_data, r_err);
    end
    for (int i = 0; i < 3; i++) begin
      run_cmd(2'b01, al[i], 16'h0);
      n_cmp++; if (r_data !== 16'hA5A5) begin
        n_bad++; $display("FAIL fill_readback_%0d: got %h want a5a5", al[i], r_data);
      end
    end
  endtask

  task automatic test_reserved();
    run_cmd(2'b11, 4'h6, 16'h1234);
    n_cmp++; if (r_err !== 1'b1 || r_data !== 16'h0) begin
      n_bad++; $display("FAIL reserved_rsp: got %h err=%b want 0000 err=1", r_data, r_err);
    end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL reserved_latency: got %0d want 1", lat); end
    n_cmp++; if (we_cnt !== 0 || re_cnt !== 0) begin
      n_bad++; $display("FAIL reserved_strobes: got we=%0d re=%0d want 0/0", we_cnt, re_cnt);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'h3; cmd_data = 16'h0;
    @(posedge clk); #1;
    cmd_op = 2'b00; cmd_addr = 4'h9; cmd_data = 16'h4242;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5) begin
        n_bad++; $display("FAIL bp_hold_%0d: got valid=%b data=%h want 1/a5a5", i, rsp_valid, rsp_data);
      end
      n_cmp++; if ({cmd_ready, ram_we_n, ram_re_n} !== 3'b011) begin
        n_bad++; $display("FAIL bp_idle_bus_%0d: got %b want 011", i, {cmd_ready, ram_we_n, ram_re_n});
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({rsp_valid, cmd_ready, ram_we_n} !== 3'b011) begin
      n_bad++; $display("FAIL bp_after_handshake: got %b want 011", {rsp_valid, cmd_ready, ram_we_n});
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++; if (ram_we_n !== 1'b0 || ram_addr !== 4'h9 || ram_wdata !== 16'h4242) begin
      n_bad++; $display("FAIL bp_pending_write: got we_n=%b addr=%h wdata=%h want 0/9/4242", ram_we_n, ram_addr, ram_wdata);
    end
    guard = 0;
    while (!rsp_valid && guard < 10) begin @(negedge clk); guard++; end
    n_cmp++; if (rsp_data !== 16'h4242) begin n_bad++; $display("FAIL bp_pending_rsp: got %h want 4242", rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    t0 = -1; t1 = -1;
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'hA; cmd_data = 16'h1111;
    for (int c = 0; c < 20 && t1 < 0; c++) begin
      if (c > 0) @(negedge clk);
      if (cmd_ready) begin
        if (t0 < 0) begin
          t0 = c;
          @(posedge clk); #1 cmd_addr = 4'hB; cmd_data = 16'h2222;
        end else begin
          t1 = c;
          @(posedge clk); #1 cmd_valid = 1'b0;
        end
      end
    end
    n_cmp++; if (t1 - t0 !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 3", t1 - t0); end
    repeat (3) @(posedge clk);
    run_cmd(2'b01, 4'hA, 16'h0);
    n_cmp++; if (r_data !== 16'h1111) begin n_bad++; $display("FAIL b2b_read_a: got %h want 1111", r_data); end
    run_cmd(2'b01, 4'hB, 16'h0);
    n_cmp++; if (r_data !== 16'h2222) begin n_bad++; $display("FAIL b2b_read_b: got %h want 2222", r_data); end
  endtask

  task automatic test_reset_mid_fill();
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 4'h0; cmd_data = 16'hFFFF;
    @(posedge clk); #1 cmd_valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(ram_we_n === 1'b0 && ram_addr === 4'h8) && guard < 30) begin @(negedge clk); guard++; end
    n_cmp++; if (guard >= 30) begin n_bad++; $display("FAIL midfill_reach_8: got timeout want counter 8"); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, ram_we_n, ram_re_n, rsp_valid, cmd_ready} !== 5'b01101) begin
      n_bad++; $display("FAIL midfill_reset_flags: got %b want 01101", {busy, ram_we_n, ram_re_n, rsp_valid, cmd_ready});
    end
    n_cmp++; if (ram_addr !== 4'h0 || ram_wdata !== 16'h0) begin
      n_bad++; $display("FAIL midfill_reset_bus: got addr=%h wdata=%h want 0/0000", ram_addr, ram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'b01, 4'h0, 16'h0);
    n_cmp++; if (r_data !== 16'h0) begin n_bad++; $display("FAIL midfill_read_0: got %h want 0000", r_data); end
    run_cmd(2'b01, 4'h8, 16'h0);
    n_cmp++; if (r_data !== 16'h0) begin n_bad++; $display("FAIL midfill_read_8: got %h want 0000", r_data); end
  endtask

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_fill();
    test_reserved();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Command sequencer that sits directly upstream of the 16×16 single-port RAM and owns its strobe, address and data pins. It accepts write, read and fill commands on a valid/ready interface. It drives the RAM's active-low write/read enables with correct single-cycle timing and returns one response per command on a second valid/ready interface. It hides the RAM's registered-read latency from the command source.

## Interface
Parameters
- AW, 4, RAM address width (16 words)
- DW, 16, RAM data width
- DEPTH, 16, number of words swept by a fill command (must equal 2^AW)

Ports
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low; shared with the RAM
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 write, 01 read, 10 fill, 11 reserved
- cmd_addr  in  AW  target address (ignored for fill)
- cmd_data  in  DW  write data / fill pattern
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_data  out  DW  read data, or echoed write/fill data
- rsp_err  out  1  response is for a reserved op
- busy  out  1  high in any state except IDLE
- ram_we_n  out  1  RAM write enable, active-low
- ram_re_n  out  1  RAM read enable, active-low
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM registered read data

## Operation
- States: IDLE, WRITE, READ, RDWAIT, FILL, RESP.
- cmd_ready = (state == IDLE). A command is accepted on a clock edge where cmd_valid && cmd_ready. The command fields are registered on that edge.
- IDLE → WRITE (op 00), READ (op 01), FILL (op 10), RESP with rsp_err=1 (op 11).
- WRITE: ram_we_n=0, ram_addr=cmd_addr, ram_wdata=cmd_data for exactly one cycle. The state then goes to RESP with rsp_data=cmd_data and rsp_err=0.
- READ: ram_re_n=0, ram_addr=cmd_addr for exactly one cycle, then RDWAIT. RDWAIT lasts one cycle; ram_rdata is captured into rsp_data on its exit edge. The state then goes to RESP.
- FILL: a 4-bit counter starts at 0. ram_we_n=0 with ram_addr=counter and ram_wdata=pattern for DEPTH consecutive cycles. The counter increments each cycle. At counter==DEPTH-1 the state goes to RESP with rsp_data=pattern. The counter wraps to 0 and never reaches an out-of-range address.
- Reserved op: no RAM strobe is issued. RESP has rsp_data=0 and rsp_err=1.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready. On the handshake edge the state goes to IDLE and rsp_valid drops.
- ram_we_n and ram_re_n are never low in the same cycle. Both are 1 in IDLE, RDWAIT and RESP.
- All RAM-side outputs and rsp_* are registered (no combinational path from cmd_* or rsp_ready to them).

## Timing
- Reset (rst_n low, asynchronous) values:
  - state=IDLE, ram_we_n=1, ram_re_n=1, ram_addr=0, ram_wdata=0
  - rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, fill counter=0
  - cmd_valid is ignored while rst_n is low
- Latency is measured from the accept edge E0 to the first cycle with rsp_valid=1:
  - write: 1 cycle after E0; strobe cycle E0→E1, rsp_valid from E1
  - read: 2 cycles; strobe E0→E1, RAM updates data_out at E1, capture at E2, rsp_valid from E2
  - fill: DEPTH cycles (16), rsp_valid from E16
  - reserved: rsp_valid from E1
- Throughput: the next command is accepted no earlier than the cycle after the response handshake. A write with rsp_ready held at 1 uses 3 cycles.
- rsp_ready low holds RESP indefinitely. No RAM access occurs during that time and cmd_ready stays 0.
- Reset mid-operation (including mid-fill): all outputs return to reset values immediately. The partial fill is not resumed. Because the RAM shares rst_n, its contents are zero afterwards.
- cmd_valid asserted while busy: the command is not accepted. The source must hold it until cmd_ready.

## Test plan
- Reset, then read addr 5 → rsp_data=0x0000, rsp_err=0; rsp_valid appears 2 cycles after accept.
- Write 0xBEEF to addr 3, then read addr 3 → write rsp_data=0xBEEF; read rsp_data=0xBEEF; ram_we_n low exactly 1 cycle; ram_re_n low exactly 1 cycle.
- Fill 0xA5A5, then read addr 0, 7 and 15 → all return 0xA5A5; ram_we_n low for exactly 16 consecutive cycles with ram_addr stepping 0..15; rsp_valid 16 cycles after accept.
- Reserved op 11 → rsp_err=1, rsp_data=0 one cycle after accept; ram_we_n and ram_re_n stay 1 throughout.
- Backpressure: read addr 3 with rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable all 5 cycles; cmd_ready=0; a pending cmd_valid is accepted only after the handshake.
- Assert rst_n low during fill at counter=8 → outputs return to reset values immediately; subsequent reads of addr 0 and addr 8 return 0x0000.
